// File: rtl/vote_pkg.sv
// Shared definitions for the vote session controller: the FSM state type,
// the candidate count, the session counter width and press-decode helpers.
package vote_pkg;

  localparam int NUM_CAND = 4;
  localparam int COUNT_W  = 8;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // True when exactly one candidate button pulsed this cycle.
  function automatic logic single_press(input logic [NUM_CAND-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // True when two or more candidate buttons pulsed in the same cycle.
  function automatic logic multi_press(input logic [NUM_CAND-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/vote_timer.sv
// Loadable down-counter with a done flag. Shared by the armed-session
// expiry and the post-vote lockout, which never run at the same time.
module vote_timer #(
  parameter int W = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load wins over counting; the counter parks at zero once it gets there.
  // NOTE: asynchronous active-low reset is in the sensitivity list so the
  // counter clears without waiting for a clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting booth session controller: the officer arms one session, the voter
// presses exactly one candidate button, a one-hot grant goes to the logger,
// then a lockout hold-off runs before the booth can be armed again.
// Optional feature: define VOTE_TIMEOUT_EN to make an armed session expire
// after TIMEOUT_CYCLES cycles without a vote (timeout pulses, FSM idles).
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                arm,
  input  logic [NUM_CAND-1:0] btn_valid,
  output logic [NUM_CAND-1:0] grant,
  output logic                ready,
  output logic                busy,
  output logic                conflict,
  output logic                timeout,
  output logic [COUNT_W-1:0]  session_count
);

`ifdef VOTE_TIMEOUT_EN
  localparam int TMR_MAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES
                                                              : LOCKOUT_CYCLES;
`else
  localparam int TMR_MAX = LOCKOUT_CYCLES;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  // The timer reads zero on the last cycle of a phase, so a phase of N
  // cycles loads N-1.
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef VOTE_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TIME_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t             state;
  logic               tmr_load;
  logic               tmr_en;
  logic [TMR_W-1:0]   tmr_load_val;
  logic               tmr_done;

  // Timer control: reload on entry to each timed phase, count while in it.
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_load_val = LOCK_LOAD;
    tmr_en       = (state == ST_LOCKOUT);
    if (state == ST_COMMIT) begin
      tmr_load = 1'b1;
    end
`ifdef VOTE_TIMEOUT_EN
    if (state == ST_ARMED) begin
      tmr_en = 1'b1;
    end
    if ((state == ST_IDLE) && arm && !mode) begin
      tmr_load     = 1'b1;
      tmr_load_val = TIME_LOAD;
    end
`endif
  end

  vote_timer #(
    .W (TMR_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_load_val),
    .done     (tmr_done)
  );

`ifdef VOTE_TIMEOUT_EN
  logic timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Session FSM with registered pulse outputs and the saturating vote count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      grant         <= '0;
      conflict      <= 1'b0;
      session_count <= '0;
`ifdef VOTE_TIMEOUT_EN
      timeout_q     <= 1'b0;
`endif
    end else begin
      grant    <= '0;
      conflict <= 1'b0;
`ifdef VOTE_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arm && !mode) begin
            state <= ST_ARMED;
          end
        end

        ST_ARMED: begin
          // Display mode aborts quietly; a valid vote beats expiry on the
          // final armed cycle; expiry suppresses a simultaneous conflict.
          if (mode) begin
            state <= ST_IDLE;
          end else if (single_press(btn_valid)) begin
            state <= ST_COMMIT;
            grant <= btn_valid;
            if (session_count != COUNT_MAX) begin
              session_count <= session_count + COUNT_W'(1);
            end
          end
`ifdef VOTE_TIMEOUT_EN
          else if (tmr_done) begin
            state     <= ST_IDLE;
            timeout_q <= 1'b1;
          end
`endif
          else if (multi_press(btn_valid)) begin
            conflict <= 1'b1;
          end
        end

        ST_COMMIT: begin
          state <= mode ? ST_IDLE : ST_LOCKOUT;
        end

        ST_LOCKOUT: begin
          if (mode || tmr_done) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready = (state == ST_ARMED);
  assign busy  = (state == ST_COMMIT) || (state == ST_LOCKOUT);

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Directed bench for vote_session_ctrl: lockout length, conflict handling,
// expiry (or persistence when VOTE_TIMEOUT_EN is undefined), mode abort,
// counter saturation and asynchronous reset.
module tb_vote_session_ctrl;

  localparam int TMO  = 8;
  localparam int LOCK = 16;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       arm;
  logic [3:0] btn_valid;
  logic [3:0] grant;
  logic       ready;
  logic       busy;
  logic       conflict;
  logic       timeout;
  logic [7:0] session_count;

  int tests  = 0;
  int failed = 0;
  int exp_cnt = 0;

  vote_session_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .LOCKOUT_CYCLES (LOCK)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .mode          (mode),
    .arm           (arm),
    .btn_valid     (btn_valid),
    .grant         (grant),
    .ready         (ready),
    .busy          (busy),
    .conflict      (conflict),
    .timeout       (timeout),
    .session_count (session_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge; grant, conflict and
  // timeout must never overlap.
  task automatic tick();
    logic overlap;
    @(posedge clock);
    #1;
    overlap = ((|grant) && conflict) || ((|grant) && timeout) || (conflict && timeout);
    check("pulse_exclusive", {7'b0, overlap}, 8'd0);
  endtask

  task automatic run_session(input logic [3:0] b);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("s_ready", {7'b0, ready}, 8'd1);
    btn_valid = b;
    tick();
    btn_valid = 4'b0000;
    if (exp_cnt != 255) exp_cnt++;
    check("s_grant", {4'b0, grant}, {4'b0, b});
    check("s_count", session_count, 8'(exp_cnt));
    repeat (LOCK) tick();
    tick();
    check("s_idle", {7'b0, busy}, 8'd0);
  endtask

  initial begin
    logic [3:0] b;
    reset = 1'b0;
    mode = 1'b0;
    arm = 1'b0;
    btn_valid = 4'b0000;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_ready", {7'b0, ready}, 8'd0);
    check("rst_busy", {7'b0, busy}, 8'd0);
    check("rst_grant", {4'b0, grant}, 8'd0);
    check("rst_conflict", {7'b0, conflict}, 8'd0);
    check("rst_timeout", {7'b0, timeout}, 8'd0);
    check("rst_count", session_count, 8'd0);
    reset = 1'b1;
    tick();

    // Press while idle is discarded
    btn_valid = 4'b0010;
    tick();
    btn_valid = 4'b0000;
    check("idle_press_grant", {4'b0, grant}, 8'd0);
    check("idle_press_busy", {7'b0, busy}, 8'd0);
    check("idle_press_ready", {7'b0, ready}, 8'd0);

    // Single vote, press three cycles after arm, full lockout with ignored inputs
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t1_ready", {7'b0, ready}, 8'd1);
    tick();
    tick();
    btn_valid = 4'b0100;
    tick();
    btn_valid = 4'b0000;
    check("t1_grant", {4'b0, grant}, 8'h04);
    check("t1_busy_commit", {7'b0, busy}, 8'd1);
    check("t1_ready_commit", {7'b0, ready}, 8'd0);
    check("t1_count", session_count, 8'd1);
    exp_cnt = 1;
    for (int i = 0; i < LOCK; i++) begin
      if (i == 5) begin
        btn_valid = 4'b0001;
        arm = 1'b1;
      end
      tick();
      btn_valid = 4'b0000;
      arm = 1'b0;
      check("t1_lock_busy", {7'b0, busy}, 8'd1);
      check("t1_lock_ready", {7'b0, ready}, 8'd0);
      check("t1_lock_grant", {4'b0, grant}, 8'd0);
    end
    tick();
    check("t1_end_busy", {7'b0, busy}, 8'd0);
    check("t1_end_ready", {7'b0, ready}, 8'd0);
    check("t1_end_count", session_count, 8'd1);

    // Multi-button conflict, arm while armed, then a valid vote
    arm = 1'b1;
    tick();
    arm = 1'b0;
    btn_valid = 4'b0011;
    tick();
    btn_valid = 4'b0000;
    check("t2_conflict", {7'b0, conflict}, 8'd1);
    check("t2_no_grant", {4'b0, grant}, 8'd0);
    check("t2_ready", {7'b0, ready}, 8'd1);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t2_conflict_clr", {7'b0, conflict}, 8'd0);
    check("t2_ready_arm", {7'b0, ready}, 8'd1);
    btn_valid = 4'b0001;
    tick();
    btn_valid = 4'b0000;
    check("t2_grant", {4'b0, grant}, 8'h01);
    check("t2_count", session_count, 8'd2);
    exp_cnt = 2;
    repeat (LOCK) tick();
    tick();
    check("t2_idle", {7'b0, busy}, 8'd0);

`ifdef VOTE_TIMEOUT_EN
    // Unused session expires TMO cycles after entering ARMED
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t3_ready", {7'b0, ready}, 8'd1);
    repeat (TMO - 1) tick();
    check("t3_ready_last", {7'b0, ready}, 8'd1);
    check("t3_no_timeout_yet", {7'b0, timeout}, 8'd0);
    tick();
    check("t3_timeout", {7'b0, timeout}, 8'd1);
    check("t3_ready_off", {7'b0, ready}, 8'd0);
    tick();
    check("t3_timeout_clr", {7'b0, timeout}, 8'd0);
    btn_valid = 4'b0100;
    tick();
    btn_valid = 4'b0000;
    check("t3_late_grant", {4'b0, grant}, 8'd0);
    check("t3_late_busy", {7'b0, busy}, 8'd0);
    check("t3_count", session_count, 8'd2);
`else
    // Without expiry an armed session waits indefinitely
    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3 * TMO) tick();
    check("t3_ready_persist", {7'b0, ready}, 8'd1);
    check("t3_timeout_tied", {7'b0, timeout}, 8'd0);
    mode = 1'b1;
    tick();
    mode = 1'b0;
    check("t3_abort_ready", {7'b0, ready}, 8'd0);
`endif

    // mode=1 while armed aborts with no grant even with a press present
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t4_ready", {7'b0, ready}, 8'd1);
    mode = 1'b1;
    btn_valid = 4'b0100;
    tick();
    btn_valid = 4'b0000;
    check("t4_abort_ready", {7'b0, ready}, 8'd0);
    check("t4_abort_grant", {4'b0, grant}, 8'd0);
    check("t4_abort_timeout", {7'b0, timeout}, 8'd0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    mode = 1'b0;
    check("t4_arm_in_display", {7'b0, ready}, 8'd0);

    // mode=1 during COMMIT: grant and count complete, no lockout
    arm = 1'b1;
    tick();
    arm = 1'b0;
    btn_valid = 4'b1000;
    tick();
    btn_valid = 4'b0000;
    check("t5_grant", {4'b0, grant}, 8'h08);
    mode = 1'b1;
    tick();
    mode = 1'b0;
    check("t5_busy", {7'b0, busy}, 8'd0);
    check("t5_count", session_count, 8'd3);
    exp_cnt = 3;

    // 256 sessions drive the counter into saturation
    for (int k = 0; k < 256; k++) begin
      b = 4'b0001 << (k % 4);
      run_session(b);
    end
    check("sat_final", session_count, 8'd255);

    // Reset mid-LOCKOUT clears everything at once
    arm = 1'b1;
    tick();
    arm = 1'b0;
    btn_valid = 4'b0010;
    tick();
    btn_valid = 4'b0000;
    tick();
    tick();
    check("t6_pre_busy", {7'b0, busy}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_busy", {7'b0, busy}, 8'd0);
    check("t6_rst_ready", {7'b0, ready}, 8'd0);
    check("t6_rst_count", session_count, 8'd0);
    check("t6_rst_grant", {4'b0, grant}, 8'd0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_after_busy", {7'b0, busy}, 8'd0);
    check("t6_after_grant", {4'b0, grant}, 8'd0);

    // Reset while armed with a press pending: nothing granted afterwards
    arm = 1'b1;
    tick();
    arm = 1'b0;
    btn_valid = 4'b0100;
    #2;
    reset = 1'b0;
    tick();
    btn_valid = 4'b0000;
    reset = 1'b1;
    tick();
    check("t7_no_grant", {4'b0, grant}, 8'd0);
    check("t7_ready", {7'b0, ready}, 8'd0);
    check("t7_count", session_count, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vote_session_ctrl.md
VOTE_SESSION_CTRL -- requirements
Module: vote_session_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the number of armed cycles before an unused session expires (minimum 2).
REQ-003 Parameter LOCKOUT_CYCLES, default 16, SHALL set the post-vote hold-off in cycles (minimum 1).
REQ-004 Port clock, input, 1, SHALL be the system clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port mode, input, 1, SHALL select voting (0) or result display (1).
REQ-007 Port arm, input, 1, SHALL be a one-cycle pulse from the officer authorising one voter.
REQ-008 Port btn_valid, input, 4, SHALL carry one-cycle debounced press pulses, bit i = candidate i+1.
REQ-009 Port grant, output, 4, SHALL carry a one-hot, one-cycle pulse to the vote logger.
REQ-010 Port ready, output, 1, SHALL indicate a session is armed and a vote is accepted.
REQ-011 Port busy, output, 1, SHALL indicate COMMIT or LOCKOUT.
REQ-012 Port conflict, output, 1, SHALL pulse one cycle when a multi-button press is rejected.
REQ-013 Port timeout, output, 1, SHALL pulse one cycle when an armed session expires.
REQ-014 Port session_count, output, 8, SHALL count committed votes, saturating at 255.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, COMMIT and LOCKOUT.
- IDLE -> ARMED when arm=1 and mode=0.
- arm is ignored in every other state.
REQ-016 In ARMED with exactly one btn_valid bit set, the FSM SHALL go to COMMIT.
- grant equals that bit during the COMMIT cycle (one-cycle latency from press).
REQ-017 In ARMED with two or more btn_valid bits set, the block SHALL pulse conflict next cycle and stay in ARMED.
- No grant is issued.
- The timeout timer is not restarted.
REQ-018 COMMIT SHALL last exactly one cycle, increment session_count (hold at 255), then enter LOCKOUT.
REQ-019 LOCKOUT SHALL last LOCKOUT_CYCLES cycles, then return to IDLE.
- btn_valid and arm are ignored throughout.
REQ-020 btn_valid in IDLE or LOCKOUT SHALL be discarded without any output effect.
REQ-021 mode=1 SHALL force the next state to IDLE from any state.
- An ARMED session is aborted with no grant and no timeout pulse.
- A COMMIT in progress completes its grant and count first.
REQ-022 ready SHALL equal (state==ARMED) and busy SHALL equal (state==COMMIT or LOCKOUT); both are registered-state decodes.
REQ-023 grant, conflict and timeout SHALL never be high in the same cycle.

Reset
REQ-024 While reset=0, the block SHALL hold state=IDLE, all timers=0, and grant, ready, busy, conflict, timeout and session_count all 0.
REQ-025 Reset asserted mid-session SHALL discard the session immediately.
- No grant is emitted after reset deasserts.

Configuration
REQ-026 Macro VOTE_TIMEOUT_EN SHALL control session expiry.
- Defined: ARMED expires after TIMEOUT_CYCLES cycles without a grant, then the FSM enters IDLE and pulses timeout.
- Undefined: ARMED persists indefinitely, timeout is tied 0, and the timeout counter is not synthesised.

Structure
REQ-027 Shared package vote_pkg SHALL hold:
- the state enum type;
- NUM_CAND=4;
- the session_count width constant.
REQ-028 Sub-module vote_timer, a loadable down-counter with a done flag, SHALL be instantiated once and shared by the ARMED timeout and the LOCKOUT hold-off.

Verification
REQ-029 arm, then btn_valid=4'b0100 three cycles later -> grant=4'b0100 for one cycle, session_count 0->1, busy high for 1+16 cycles, then IDLE.
REQ-030 arm, then btn_valid=4'b0011 -> conflict pulse, no grant, ready stays 1; a later 4'b0001 -> grant=4'b0001.
REQ-031 With VOTE_TIMEOUT_EN and TIMEOUT_CYCLES=8: arm, no press -> timeout pulse 8 cycles after entering ARMED, then ready=0; a press afterwards -> no grant.
REQ-032 Press during LOCKOUT, and arm during ARMED -> ignored; session_count increments exactly once per session.
REQ-033 Drive 256 sessions -> session_count saturates at 255.
- mode=1 while ARMED -> IDLE next cycle, no grant.
- reset=0 in LOCKOUT -> all outputs 0 immediately.
